ram_1port_arb: RTL

- Round-robin arbiter and sequencer that shares one single-port RAM (ram_1port) between NUM_REQ requesters.
- Grants at most one access per cycle and drives the RAM cen/wen/addr/data pins.
- Returns read data with a per-requester valid one cycle after the grant.
- Supports bounded bus locking, so a requester can issue back-to-back beats without interleaving.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_1port_arb_if.sv | 34 +++
 rtl/rr_pick.sv | 31 +++
 rtl/ram_1port_arb.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter: FSM encoding and
// the pointer-width helper used to size round-robin indices.
package ram_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int PTR_W       = ptr_width(DEF_NUM_REQ);

endpackage

// File: rtl/ram_1port_arb_if.sv
// Requester-side and RAM-side bus of the single-port RAM arbiter.
// slave is the arbiter's view; master is the requesters plus the RAM.
interface ram_1port_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  logic                          ram_cen;
  logic                          ram_wen;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0]         ram_data;
  logic [DATA_WIDTH-1:0]         ram_q;

  modport slave (
    input  req, we, lock, addr, wdata, ram_q,
    output gnt, rvalid, rdata, ram_cen, ram_wen, ram_addr, ram_data
  );

  modport master (
    output req, we, lock, addr, wdata, ram_q,
    input  gnt, rvalid, rdata, ram_cen, ram_wen, ram_addr, ram_data
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping
// modulo N, and returns the first set requester as one-hot and as index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  // First requester at or after ptr (circularly) wins.
  always_comb begin
    logic [PW-1:0] j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/ram_1port_arb.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters,
// with bounded bus locking and one-cycle read-data return.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   ARB   | round-robin search from ptr; a locked grant moves to LOCK
//   LOCK  | only requester own may be granted; at most MAX_LOCK beats total
module ram_1port_arb
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LOCK   = 4
) (
  input logic             clk,
  input logic             rstn,
  ram_1port_arb_if.slave  bus
);

  localparam int PW = ptr_width(NUM_REQ);
  localparam int LW = $clog2(MAX_LOCK + 1);

  arb_state_e          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       own_q, own_d;
  logic [LW-1:0]       lcnt_q, lcnt_d;
  logic [NUM_REQ-1:0]  rvalid_q;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [PW-1:0]       pick_idx;
  logic                pick_any;

  logic [NUM_REQ-1:0]  gnt_c;
  logic [PW-1:0]       gidx;
  logic                gany;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return PW'((int'(i) + 1) % NUM_REQ);
  endfunction

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next-state, pointer/lock bookkeeping and the combinational grant.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    lcnt_d  = lcnt_q;
    gnt_c   = '0;
    gidx    = '0;
    gany    = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_any) begin
          gnt_c = pick_oh;
          gidx  = pick_idx;
          gany  = 1'b1;
          ptr_d = next_idx(pick_idx);
          if (bus.lock[pick_idx] && (MAX_LOCK > 1)) begin
            state_d = LOCK;
            own_d   = pick_idx;
            lcnt_d  = LW'(1);
          end
        end
      end
      LOCK: begin
        if (bus.req[own_q]) begin
          gnt_c[own_q] = 1'b1;
          gidx         = own_q;
          gany         = 1'b1;
        end
        if (bus.req[own_q] && bus.lock[own_q] && (int'(lcnt_q) < MAX_LOCK - 1)) begin
          lcnt_d = lcnt_q + LW'(1);
        end else begin
          // Owner re-competes behind everyone else once its lock ends.
          state_d = ARB;
          ptr_d   = next_idx(own_q);
          lcnt_d  = '0;
        end
      end
      default: state_d = ARB;
    endcase
    if (!rstn) begin
      gnt_c = '0;
      gany  = 1'b0;
    end
  end

  // FSM, pointer, owner and lock-count registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB;
      ptr_q   <= '0;
      own_q   <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // A granted read returns its valid exactly one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rvalid_q <= '0;
    else       rvalid_q <= gnt_c & ~bus.we;
  end

  assign bus.gnt      = gnt_c;
  assign bus.rvalid   = rvalid_q;
  // Mask the RAM output when nothing is being returned.
  assign bus.rdata    = (|rvalid_q) ? bus.ram_q : '0;
  assign bus.ram_cen  = gany;
  assign bus.ram_wen  = gany & bus.we[gidx];
  assign bus.ram_addr = gany ? bus.addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.ram_data = gany ? bus.wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule
